// File: rtl/ysyx_23060059_xbar_pkg.sv
// Shared types for the LSU crossbar: decode targets, response codes, FSM states.
package ysyx_23060059_xbar_pkg;

    typedef enum logic [1:0] {TGT_MEM = 2'd0, TGT_CLINT = 2'd1, TGT_ERR = 2'd2} tgt_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_e;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR} w_state_e;

endpackage

// File: rtl/ysyx_23060059_xbar_decode.sv
// Maps a byte address onto the memory, CLINT or error target.
module ysyx_23060059_xbar_decode
    import ysyx_23060059_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE  = 32'h0200_0000,
    parameter logic [31:0] CLINT_LIMIT = 32'h0200_FFFF,
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000
) (
    input  logic [31:0] addr,
    output tgt_e        tgt
);

    always_comb begin
        if (addr >= CLINT_BASE && addr <= CLINT_LIMIT) tgt = TGT_CLINT;
        else if (addr >= MEM_BASE)                     tgt = TGT_MEM;
        else                                           tgt = TGT_ERR;
    end

endmodule

// File: rtl/ysyx_23060059_xbar.sv
// 1-to-2 AXI crossbar (memory / CLINT) with independent read and write FSMs and DECERR for unmapped addresses.
module ysyx_23060059_xbar
    import ysyx_23060059_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE  = 32'h0200_0000,
    parameter logic [31:0] CLINT_LIMIT = 32'h0200_FFFF,
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000
) (
    input  logic clock, input logic reset,
    input  logic s_arvalid, output logic s_arready, input logic [31:0] s_araddr, input logic [3:0] s_arid,
    input  logic [7:0] s_arlen, input logic [2:0] s_arsize, input logic [1:0] s_arburst,
    output logic s_rvalid, input logic s_rready, output logic [63:0] s_rdata, output logic [1:0] s_rresp,
    output logic s_rlast, output logic [3:0] s_rid,
    input  logic s_awvalid, output logic s_awready, input logic [31:0] s_awaddr, input logic [3:0] s_awid,
    input  logic [7:0] s_awlen, input logic [2:0] s_awsize, input logic [1:0] s_awburst,
    input  logic s_wvalid, output logic s_wready, input logic [63:0] s_wdata, input logic [7:0] s_wstrb,
    input  logic s_wlast,
    output logic s_bvalid, input logic s_bready, output logic [1:0] s_bresp, output logic [3:0] s_bid,
    output logic m0_arvalid, input logic m0_arready, output logic [31:0] m0_araddr, output logic [3:0] m0_arid,
    output logic [7:0] m0_arlen, output logic [2:0] m0_arsize, output logic [1:0] m0_arburst,
    input  logic m0_rvalid, output logic m0_rready, input logic [63:0] m0_rdata, input logic [1:0] m0_rresp,
    input  logic m0_rlast, input logic [3:0] m0_rid,
    output logic m0_awvalid, input logic m0_awready, output logic [31:0] m0_awaddr, output logic [3:0] m0_awid,
    output logic [7:0] m0_awlen, output logic [2:0] m0_awsize, output logic [1:0] m0_awburst,
    output logic m0_wvalid, input logic m0_wready, output logic [63:0] m0_wdata, output logic [7:0] m0_wstrb,
    output logic m0_wlast,
    input  logic m0_bvalid, output logic m0_bready, input logic [1:0] m0_bresp, input logic [3:0] m0_bid,
    output logic m1_arvalid, input logic m1_arready, output logic [31:0] m1_araddr, output logic [3:0] m1_arid,
    output logic [7:0] m1_arlen, output logic [2:0] m1_arsize, output logic [1:0] m1_arburst,
    input  logic m1_rvalid, output logic m1_rready, input logic [63:0] m1_rdata, input logic [1:0] m1_rresp,
    input  logic m1_rlast, input logic [3:0] m1_rid,
    output logic m1_awvalid, input logic m1_awready, output logic [31:0] m1_awaddr, output logic [3:0] m1_awid,
    output logic [7:0] m1_awlen, output logic [2:0] m1_awsize, output logic [1:0] m1_awburst,
    output logic m1_wvalid, input logic m1_wready, output logic [63:0] m1_wdata, output logic [7:0] m1_wstrb,
    output logic m1_wlast,
    input  logic m1_bvalid, output logic m1_bready, input logic [1:0] m1_bresp, input logic [3:0] m1_bid
);

    tgt_e ar_tgt, aw_tgt;

    ysyx_23060059_xbar_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_LIMIT(CLINT_LIMIT), .MEM_BASE(MEM_BASE))
        u_ar_decode (.addr(s_araddr), .tgt(ar_tgt));
    ysyx_23060059_xbar_decode #(.CLINT_BASE(CLINT_BASE), .CLINT_LIMIT(CLINT_LIMIT), .MEM_BASE(MEM_BASE))
        u_aw_decode (.addr(s_awaddr), .tgt(aw_tgt));

    r_state_e    r_state_q, r_state_d;
    tgt_e        r_tgt_p0;
    logic [31:0] ar_addr_p0;
    logic [3:0]  ar_id_p0;
    logic [7:0]  ar_len_p0, r_cnt_q;
    logic [2:0]  ar_size_p0;
    logic [1:0]  ar_burst_p0;

    w_state_e    w_state_q, w_state_d;
    tgt_e        w_tgt_p0;
    logic [31:0] aw_addr_p0;
    logic [3:0]  aw_id_p0;
    logic [7:0]  aw_len_p0;
    logic [2:0]  aw_size_p0;
    logic [1:0]  aw_burst_p0;
    logic        err_wdone_q;

    logic r_clint, w_clint;
    assign r_clint = (r_tgt_p0 == TGT_CLINT);
    assign w_clint = (w_tgt_p0 == TGT_CLINT);

    // Upstream AR -> latched request (stage p0); downstream AR is driven only from here
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            r_tgt_p0    <= TGT_MEM;
            ar_addr_p0  <= '0;
            ar_id_p0    <= '0;
            ar_len_p0   <= '0;
            ar_size_p0  <= '0;
            ar_burst_p0 <= '0;
            r_cnt_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (r_state_q == R_IDLE && s_arvalid) begin
                r_tgt_p0    <= ar_tgt;
                ar_addr_p0  <= s_araddr;
                ar_id_p0    <= s_arid;
                ar_len_p0   <= s_arlen;
                ar_size_p0  <= s_arsize;
                ar_burst_p0 <= s_arburst;
                r_cnt_q     <= '0;
            end else if (r_state_q == R_ERR && s_rready) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
        end
    end

    // Everything valid/ready is held low while reset is high
    always_comb begin
        r_state_d  = r_state_q;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        s_rdata    = '0;
        s_rresp    = OKAY;
        s_rlast    = 1'b0;
        s_rid      = '0;
        m0_arvalid = 1'b0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
        m1_arvalid = 1'b0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
        m0_rready  = 1'b0;
        m1_rready  = 1'b0;
        if (!reset) begin
            case (r_state_q)
                R_IDLE: begin
                    s_arready = 1'b1;
                    if (s_arvalid) r_state_d = (ar_tgt == TGT_ERR) ? R_ERR : R_ADDR;
                end
                R_ADDR: begin
                    if (r_clint) begin
                        m1_arvalid = 1'b1; m1_araddr = ar_addr_p0; m1_arid = ar_id_p0;
                        m1_arlen = ar_len_p0; m1_arsize = ar_size_p0; m1_arburst = ar_burst_p0;
                        if (m1_arready) r_state_d = R_DATA;
                    end else begin
                        m0_arvalid = 1'b1; m0_araddr = ar_addr_p0; m0_arid = ar_id_p0;
                        m0_arlen = ar_len_p0; m0_arsize = ar_size_p0; m0_arburst = ar_burst_p0;
                        if (m0_arready) r_state_d = R_DATA;
                    end
                end
                R_DATA: begin
                    s_rvalid = r_clint ? m1_rvalid : m0_rvalid;
                    s_rdata  = r_clint ? m1_rdata  : m0_rdata;
                    s_rresp  = r_clint ? m1_rresp  : m0_rresp;
                    s_rlast  = r_clint ? m1_rlast  : m0_rlast;
                    s_rid    = r_clint ? m1_rid    : m0_rid;
                    if (r_clint) m1_rready = s_rready;
                    else         m0_rready = s_rready;
                    if (s_rvalid && s_rready && s_rlast) r_state_d = R_IDLE;
                end
                R_ERR: begin
                    s_rvalid = 1'b1;
                    s_rresp  = DECERR;
                    s_rid    = ar_id_p0;
                    s_rlast  = (r_cnt_q == ar_len_p0);
                    if (s_rready && s_rlast) r_state_d = R_IDLE;
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    // Upstream AW -> latched request (stage p0)
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            w_tgt_p0    <= TGT_MEM;
            aw_addr_p0  <= '0;
            aw_id_p0    <= '0;
            aw_len_p0   <= '0;
            aw_size_p0  <= '0;
            aw_burst_p0 <= '0;
            err_wdone_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (w_state_q == W_IDLE && s_awvalid) begin
                w_tgt_p0    <= aw_tgt;
                aw_addr_p0  <= s_awaddr;
                aw_id_p0    <= s_awid;
                aw_len_p0   <= s_awlen;
                aw_size_p0  <= s_awsize;
                aw_burst_p0 <= s_awburst;
                err_wdone_q <= 1'b0;
            end else if (w_state_q == W_ERR && !err_wdone_q && s_wvalid && s_wlast) begin
                err_wdone_q <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        s_bresp    = OKAY;
        s_bid      = '0;
        m0_awvalid = 1'b0; m0_awaddr = '0; m0_awid = '0; m0_awlen = '0; m0_awsize = '0; m0_awburst = '0;
        m1_awvalid = 1'b0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = '0; m1_awburst = '0;
        m0_wvalid  = 1'b0; m0_wdata = '0; m0_wstrb = '0; m0_wlast = 1'b0;
        m1_wvalid  = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0;
        m0_bready  = 1'b0;
        m1_bready  = 1'b0;
        if (!reset) begin
            case (w_state_q)
                W_IDLE: begin
                    s_awready = 1'b1;
                    if (s_awvalid) w_state_d = (aw_tgt == TGT_ERR) ? W_ERR : W_ADDR;
                end
                W_ADDR: begin
                    if (w_clint) begin
                        m1_awvalid = 1'b1; m1_awaddr = aw_addr_p0; m1_awid = aw_id_p0;
                        m1_awlen = aw_len_p0; m1_awsize = aw_size_p0; m1_awburst = aw_burst_p0;
                        if (m1_awready) w_state_d = W_DATA;
                    end else begin
                        m0_awvalid = 1'b1; m0_awaddr = aw_addr_p0; m0_awid = aw_id_p0;
                        m0_awlen = aw_len_p0; m0_awsize = aw_size_p0; m0_awburst = aw_burst_p0;
                        if (m0_awready) w_state_d = W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_clint) begin
                        m1_wvalid = s_wvalid; m1_wdata = s_wdata; m1_wstrb = s_wstrb; m1_wlast = s_wlast;
                        s_wready  = m1_wready;
                    end else begin
                        m0_wvalid = s_wvalid; m0_wdata = s_wdata; m0_wstrb = s_wstrb; m0_wlast = s_wlast;
                        s_wready  = m0_wready;
                    end
                    if (s_wvalid && s_wready && s_wlast) w_state_d = W_RESP;
                end
                W_RESP: begin
                    s_bvalid = w_clint ? m1_bvalid : m0_bvalid;
                    s_bresp  = w_clint ? m1_bresp  : m0_bresp;
                    s_bid    = w_clint ? m1_bid    : m0_bid;
                    if (w_clint) m1_bready = s_bready;
                    else         m0_bready = s_bready;
                    if (s_bvalid && s_bready) w_state_d = W_IDLE;
                end
                W_ERR: begin
                    // Sink the whole burst before answering, so the LSU never sees B ahead of its last W
                    if (!err_wdone_q) begin
                        s_wready = 1'b1;
                    end else begin
                        s_bvalid = 1'b1;
                        s_bresp  = DECERR;
                        s_bid    = aw_id_p0;
                        if (s_bready) w_state_d = W_IDLE;
                    end
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060059_xbar.sv
// Table-driven bench for the LSU crossbar with behavioural memory and CLINT slaves.
module tb_ysyx_23060059_xbar;

    logic clock = 1'b0, reset;
    always #5 clock = ~clock;

    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, s_awvalid, s_awready;
    logic s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_awaddr;
    logic [3:0]  s_arid, s_rid, s_awid, s_bid;
    logic [7:0]  s_arlen, s_awlen, s_wstrb;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
    logic [63:0] s_rdata, s_wdata;

    logic m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_wlast, m0_bready;
    logic m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_wlast, m1_bready;
    logic [31:0] m0_araddr, m0_awaddr, m1_araddr, m1_awaddr;
    logic [3:0]  m0_arid, m0_awid, m1_arid, m1_awid;
    logic [7:0]  m0_arlen, m0_awlen, m1_arlen, m1_awlen, m0_wstrb, m1_wstrb;
    logic [2:0]  m0_arsize, m0_awsize, m1_arsize, m1_awsize;
    logic [1:0]  m0_arburst, m0_awburst, m1_arburst, m1_awburst;
    logic [63:0] m0_wdata, m1_wdata;

    // slave model inputs to the DUT, indexed 0=memory 1=CLINT
    logic        mi_arready[2], mi_rvalid[2], mi_rlast[2], mi_awready[2], mi_wready[2], mi_bvalid[2];
    logic [63:0] mi_rdata[2];
    logic [1:0]  mi_rresp[2], mi_bresp[2];
    logic [3:0]  mi_rid[2], mi_bid[2];
    // DUT outputs towards the slaves, same indexing
    logic        mo_arvalid[2], mo_rready[2], mo_awvalid[2], mo_wvalid[2], mo_wlast[2], mo_bready[2];
    logic [31:0] mo_araddr[2], mo_awaddr[2];
    logic [3:0]  mo_arid[2], mo_awid[2];
    logic [7:0]  mo_arlen[2], mo_wstrb[2];
    logic [63:0] mo_wdata[2];

    assign mo_arvalid[0] = m0_arvalid; assign mo_arvalid[1] = m1_arvalid;
    assign mo_araddr[0]  = m0_araddr;  assign mo_araddr[1]  = m1_araddr;
    assign mo_arid[0]    = m0_arid;    assign mo_arid[1]    = m1_arid;
    assign mo_arlen[0]   = m0_arlen;   assign mo_arlen[1]   = m1_arlen;
    assign mo_rready[0]  = m0_rready;  assign mo_rready[1]  = m1_rready;
    assign mo_awvalid[0] = m0_awvalid; assign mo_awvalid[1] = m1_awvalid;
    assign mo_awaddr[0]  = m0_awaddr;  assign mo_awaddr[1]  = m1_awaddr;
    assign mo_awid[0]    = m0_awid;    assign mo_awid[1]    = m1_awid;
    assign mo_wvalid[0]  = m0_wvalid;  assign mo_wvalid[1]  = m1_wvalid;
    assign mo_wdata[0]   = m0_wdata;   assign mo_wdata[1]   = m1_wdata;
    assign mo_wstrb[0]   = m0_wstrb;   assign mo_wstrb[1]   = m1_wstrb;
    assign mo_wlast[0]   = m0_wlast;   assign mo_wlast[1]   = m1_wlast;
    assign mo_bready[0]  = m0_bready;  assign mo_bready[1]  = m1_bready;

    ysyx_23060059_xbar dut (
        .clock(clock), .reset(reset),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .m0_arvalid(m0_arvalid), .m0_arready(mi_arready[0]), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(mi_rvalid[0]), .m0_rready(m0_rready), .m0_rdata(mi_rdata[0]), .m0_rresp(mi_rresp[0]),
        .m0_rlast(mi_rlast[0]), .m0_rid(mi_rid[0]),
        .m0_awvalid(m0_awvalid), .m0_awready(mi_awready[0]), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid),
        .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
        .m0_wvalid(m0_wvalid), .m0_wready(mi_wready[0]), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_wlast(m0_wlast),
        .m0_bvalid(mi_bvalid[0]), .m0_bready(m0_bready), .m0_bresp(mi_bresp[0]), .m0_bid(mi_bid[0]),
        .m1_arvalid(m1_arvalid), .m1_arready(mi_arready[1]), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(mi_rvalid[1]), .m1_rready(m1_rready), .m1_rdata(mi_rdata[1]), .m1_rresp(mi_rresp[1]),
        .m1_rlast(mi_rlast[1]), .m1_rid(mi_rid[1]),
        .m1_awvalid(m1_awvalid), .m1_awready(mi_awready[1]), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(mi_wready[1]), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast),
        .m1_bvalid(mi_bvalid[1]), .m1_bready(m1_bready), .m1_bresp(mi_bresp[1]), .m1_bid(mi_bid[1])
    );

    function automatic logic [63:0] base_of(input int i);
        return (i == 0) ? 64'hDEAD : 64'h1234;
    endfunction

    // slave model state and monitor counters
    logic       rd_busy[2], wr_busy[2], b_pend[2];
    logic [3:0] rd_id[2], wr_id[2];
    logic [7:0] rd_len[2], rd_beat[2];
    int ar_cnt[2] = '{0, 0}, aw_cnt[2] = '{0, 0}, w_cnt[2] = '{0, 0}, act_cnt[2] = '{0, 0};
    logic [31:0] ar_last[2], aw_last[2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mi_arready[i] = !rd_busy[i];
            mi_rvalid[i]  = rd_busy[i];
            mi_rdata[i]   = base_of(i) + 64'(rd_beat[i]);
            mi_rresp[i]   = 2'b00;
            mi_rlast[i]   = (rd_beat[i] == rd_len[i]);
            mi_rid[i]     = rd_id[i];
            mi_awready[i] = !wr_busy[i];
            mi_wready[i]  = wr_busy[i] && !b_pend[i];
            mi_bvalid[i]  = b_pend[i];
            mi_bresp[i]   = 2'b00;
            mi_bid[i]     = wr_id[i];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rd_busy[i] <= 1'b0; rd_beat[i] <= '0; rd_len[i] <= '0; rd_id[i] <= '0;
                wr_busy[i] <= 1'b0; b_pend[i] <= 1'b0; wr_id[i] <= '0;
            end else begin
                if (mo_arvalid[i] && mi_arready[i]) begin
                    rd_busy[i] <= 1'b1; rd_id[i] <= mo_arid[i]; rd_len[i] <= mo_arlen[i]; rd_beat[i] <= '0;
                    ar_cnt[i] <= ar_cnt[i] + 1; ar_last[i] <= mo_araddr[i];
                end else if (mi_rvalid[i] && mo_rready[i]) begin
                    if (mi_rlast[i]) rd_busy[i] <= 1'b0;
                    else             rd_beat[i] <= rd_beat[i] + 8'd1;
                end
                if (mo_awvalid[i] && mi_awready[i]) begin
                    wr_busy[i] <= 1'b1; wr_id[i] <= mo_awid[i];
                    aw_cnt[i] <= aw_cnt[i] + 1; aw_last[i] <= mo_awaddr[i];
                end
                if (mo_wvalid[i] && mi_wready[i]) begin
                    w_cnt[i] <= w_cnt[i] + 1;
                    if (mo_wlast[i]) b_pend[i] <= 1'b1;
                end
                if (mi_bvalid[i] && mo_bready[i]) begin
                    b_pend[i] <= 1'b0; wr_busy[i] <= 1'b0;
                end
            end
            if (mo_arvalid[i] || mo_rready[i] || mo_awvalid[i] || mo_wvalid[i] || mo_bready[i] ||
                mo_wlast[i] || (|mo_araddr[i]) || (|mo_awaddr[i]) || (|mo_wdata[i]) || (|mo_wstrb[i]) ||
                (|mo_arid[i]) || (|mo_arlen[i]) || (|mo_awid[i]))
                act_cnt[i] <= act_cnt[i] + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int t = 0;
        s_arvalid = 1'b1; s_araddr = a; s_arid = id; s_arlen = len; s_arsize = 3'd3; s_arburst = 2'b01;
        #1;
        while (!s_arready && t < 50) begin @(negedge clock); #1; t++; end
        chk("ar_accept", 64'(s_arready), 64'd1);
        @(negedge clock);
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int t = 0;
        s_awvalid = 1'b1; s_awaddr = a; s_awid = id; s_awlen = len; s_awsize = 3'd3; s_awburst = 2'b01;
        #1;
        while (!s_awready && t < 50) begin @(negedge clock); #1; t++; end
        chk("aw_accept", 64'(s_awready), 64'd1);
        @(negedge clock);
        s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    endtask

    // tgt: 0 memory, 1 CLINT, 2 unmapped
    task automatic rd_txn(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input int tgt, input logic toggle);
        int a0 = ar_cnt[0], a1 = ar_cnt[1];
        int k = 0, t = 0;
        logic ar_seen = 1'b0;
        logic [63:0] exp_d;
        send_ar(a, id, len);
        while (k <= int'(len) && t < 300) begin
            s_rready = toggle ? t[0] : 1'b1;
            #1;
            if (s_arready) ar_seen = 1'b1;
            if (s_rvalid && s_rready) begin
                exp_d = (tgt == 2) ? 64'd0 : base_of(tgt) + 64'(k);
                chk("r_data", s_rdata, exp_d);
                chk("r_resp", 64'(s_rresp), (tgt == 2) ? 64'd3 : 64'd0);
                chk("r_id",   64'(s_rid), 64'(id));
                chk("r_last", 64'(s_rlast), 64'(k == int'(len)));
                k++;
            end
            @(negedge clock);
            t++;
        end
        s_rready = 1'b0;
        chk("r_beats", 64'(k), 64'(len) + 64'd1);
        chk("r_arready_busy", 64'(ar_seen), 64'd0);
        chk("r_m0_ar_count", 64'(ar_cnt[0] - a0), 64'(tgt == 0));
        chk("r_m1_ar_count", 64'(ar_cnt[1] - a1), 64'(tgt == 1));
        if (tgt != 2) chk("r_slave_addr", 64'(ar_last[tgt]), 64'(a));
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input int tgt);
        int a0 = aw_cnt[0], a1 = aw_cnt[1], w0 = w_cnt[0], w1 = w_cnt[1];
        int t;
        send_aw(a, id, len);
        for (int k = 0; k <= int'(len); k++) begin
            s_wvalid = 1'b1; s_wdata = 64'hA5A5_0000_0000_0000 + 64'(k); s_wstrb = 8'hFF;
            s_wlast = (k == int'(len));
            t = 0; #1;
            while (!s_wready && t < 50) begin @(negedge clock); #1; t++; end
            chk("w_accept", 64'(s_wready), 64'd1);
            @(negedge clock);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b1;
        t = 0; #1;
        while (!s_bvalid && t < 50) begin @(negedge clock); #1; t++; end
        chk("b_valid", 64'(s_bvalid), 64'd1);
        chk("b_resp", 64'(s_bresp), (tgt == 2) ? 64'd3 : 64'd0);
        chk("b_id", 64'(s_bid), 64'(id));
        @(negedge clock);
        s_bready = 1'b0;
        chk("w_m0_aw_count", 64'(aw_cnt[0] - a0), 64'(tgt == 0));
        chk("w_m1_aw_count", 64'(aw_cnt[1] - a1), 64'(tgt == 1));
        chk("w_m0_beats", 64'(w_cnt[0] - w0), (tgt == 0) ? 64'(len) + 64'd1 : 64'd0);
        chk("w_m1_beats", 64'(w_cnt[1] - w1), (tgt == 1) ? 64'(len) + 64'd1 : 64'd0);
        if (tgt != 2) chk("w_slave_addr", 64'(aw_last[tgt]), 64'(a));
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        int          tgt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int k, t, snap0, snap1;
        logic rv;
        vecs[0]  = '{1'b0, 32'h8000_0010, 4'h1, 8'd0, 0};
        vecs[1]  = '{1'b0, 32'h0200_BFF8, 4'h5, 8'd0, 1};
        vecs[2]  = '{1'b0, 32'h0200_0000, 4'h2, 8'd1, 1};
        vecs[3]  = '{1'b0, 32'h0200_FFFF, 4'h3, 8'd0, 1};
        vecs[4]  = '{1'b0, 32'h0201_0000, 4'h4, 8'd1, 2};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFF, 4'h6, 8'd0, 2};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF8, 4'h7, 8'd2, 0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 4'h8, 8'd0, 2};
        vecs[8]  = '{1'b1, 32'h1000_0000, 4'h9, 8'd3, 2};
        vecs[9]  = '{1'b1, 32'h8000_0100, 4'hA, 8'd1, 0};
        vecs[10] = '{1'b1, 32'h0200_4000, 4'hB, 8'd0, 1};
        vecs[11] = '{1'b1, 32'h0201_0000, 4'hC, 8'd0, 2};

        reset = 1'b1;
        s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_rready = 0;
        s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_m0_arvalid", 64'(m0_arvalid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_arready", 64'(s_arready), 64'd1);
        chk("post_rst_awready", 64'(s_awready), 64'd1);
        @(negedge clock);

        for (int v = 0; v < 12; v++) begin
            snap0 = act_cnt[0]; snap1 = act_cnt[1];
            if (vecs[v].wr) wr_txn(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].tgt);
            else            rd_txn(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].tgt, 1'b0);
            if (vecs[v].tgt != 0) chk("m0_untouched", 64'(act_cnt[0] - snap0), 64'd0);
            if (vecs[v].tgt != 1) chk("m1_untouched", 64'(act_cnt[1] - snap1), 64'd0);
        end

        // read of CLINT and write of memory launched together
        fork
            rd_txn(32'h0200_4000, 4'h9, 8'd1, 1, 1'b0);
            wr_txn(32'h8000_2000, 4'hA, 8'd1, 0);
        join
        @(negedge clock);

        // 8-beat burst with the LSU stalling every other cycle
        rd_txn(32'h8000_0040, 4'hB, 8'd7, 0, 1'b1);

        // reset in the middle of a 4-beat read, after two beats
        send_ar(32'h8000_0080, 4'hD, 8'd3);
        k = 0; t = 0; s_rready = 1'b1;
        while (k < 2 && t < 50) begin
            #1;
            if (s_rvalid && s_rready) k++;
            @(negedge clock);
            t++;
        end
        chk("mid_rst_pre_beats", 64'(k), 64'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("mid_rst_arready", 64'(s_arready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_arready_after", 64'(s_arready), 64'd1);
        rv = 1'b0;
        repeat (4) begin
            if (s_rvalid) rv = 1'b1;
            @(negedge clock);
            #1;
        end
        chk("mid_rst_no_rvalid", 64'(rv), 64'd0);
        s_rready = 1'b0;
        @(negedge clock);
        rd_txn(32'h8000_0200, 4'hE, 8'd1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060059_xbar.md
YSYX_23060059_XBAR -- requirements
Module: ysyx_23060059_xbar

Interface
REQ-001 SHALL have parameter CLINT_BASE, default 32'h0200_0000, meaning the first CLINT byte address.
REQ-002 SHALL have parameter CLINT_LIMIT, default 32'h0200_FFFF, meaning the last CLINT byte address, inclusive.
REQ-003 SHALL have parameter MEM_BASE, default 32'h8000_0000, meaning the first memory address; memory runs to 32'hFFFF_FFFF.
REQ-004 SHALL have port clock, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have upstream bundle s_ar{valid,ready,addr[31:0],id[3:0],len[7:0],size[2:0],burst[1:0]}: read address from the CPU LSU; ready is an output, the rest are inputs.
REQ-007 SHALL have upstream bundle s_r{valid,ready,data[63:0],resp[1:0],last,id[3:0]}: read data to the LSU; ready is an input, the rest are outputs.
REQ-008 SHALL have upstream bundles s_aw (fields as s_ar), s_w{valid,ready,data[63:0],strb[7:0],last} and s_b{valid,ready,resp[1:0],id[3:0]}, with the same direction convention.
REQ-009 SHALL have downstream bundles m0_* (memory) and m1_* (CLINT), each mirroring all five s_* channels with directions reversed.

Function
REQ-010 Address decode: CLINT if CLINT_BASE<=addr<=CLINT_LIMIT; else MEM if addr>=MEM_BASE; else ERR.
REQ-011 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA and R_ERR.
REQ-012 R_IDLE: on s_arvalid, latch addr/id/len/size/burst and the decoded target; go to R_ADDR, or to R_ERR if the target is ERR; s_arready=1 in R_IDLE only.
REQ-013 R_ADDR: drive the target's m*_ar* from the latched values, with arvalid=1; on target arready go to R_DATA.
REQ-014 R_DATA: connect the target r channel combinationally to s_r and the target's rready to s_rready; on rvalid&rready&rlast go to R_IDLE.
REQ-015 R_ERR: return len+1 beats of s_rvalid=1, rresp=2'b11, rdata=0 and the latched id, with rlast on the final beat; then go to R_IDLE.
REQ-016 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP and W_ERR, and SHALL be independent of the read FSM.
REQ-017 W_IDLE: accept s_aw with s_awready=1 and latch it plus the target; ERR targets go to W_ERR.
REQ-018 W_ADDR: present awvalid to the target; on awready go to W_DATA.
REQ-019 W_DATA: pass s_w through to the target; on wvalid&wready&wlast go to W_RESP.
REQ-020 W_RESP: pass the target's b channel through; on bvalid&bready go to W_IDLE.
REQ-021 W_ERR: sink W beats with s_wready=1 until wlast, then drive s_bvalid with bresp=2'b11 and the latched id until s_bready; then go to W_IDLE.
REQ-022 The non-selected slave SHALL see all valid/ready outputs at 0, and its address/data outputs SHALL be 0.
REQ-023 At most one outstanding read and one outstanding write SHALL exist; s_arready=0 and s_awready=0 outside their IDLE states.
REQ-024 A simultaneous read and write to the same slave SHALL both proceed; each slave arbitrates its own channels.
REQ-025 Minimum latency SHALL be one cycle from AR acceptance to m*_arvalid, which is registered; the R and B paths SHALL add zero cycles.
REQ-026 Boundary values: addresses CLINT_LIMIT+1 and MEM_BASE-1 decode as ERR; CLINT_BASE and CLINT_LIMIT decode as CLINT.

Reset
REQ-027 On reset, both FSMs SHALL enter their IDLE state, all valid/ready outputs SHALL be 0 and the latched registers SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon it with no completion beat on s_r or s_b; a downstream slave is reset by the same signal.
REQ-029 The first s_arready or s_awready SHALL be asserted in the cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the target enum {TGT_MEM, TGT_CLINT, TGT_ERR}, the resp constants OKAY=2'b00 and DECERR=2'b11, and both FSM state enums.
REQ-031 Address decoding SHALL be a sub-module ysyx_23060059_xbar_decode (addr in, target out), instantiated for AR and for AW.

Verification
REQ-032 Read at 0x8000_0010 with len=0, memory model returning 0xDEAD: exactly one m0 AR with the same addr; s_rdata=0xDEAD, rlast=1, resp=0; m1 stays idle.
REQ-033 Read at 0x0200_BFF8 with CLINT data 0x1234: routed to m1; s_r returns 0x1234 with id preserved.
REQ-034 Write to 0x1000_0000 with len=3: four W beats are sunk; bresp=2'b11; m0 and m1 see no valid at any time.
REQ-035 Concurrent read of CLINT and write of memory in the same cycle: both complete, and rid and bid match their respective requests.
REQ-036 Read with len=7 and s_rready toggled every other cycle: all 8 beats arrive in order; s_arready stays 0 until the last handshake.
REQ-037 Reset asserted in R_DATA after beat 2 of 4: no further s_rvalid; s_arready=1 one cycle after reset drops.
